// File: rtl/exe_wb_pipe_reg.sv
// EXE->WB pipeline register with a 2-entry skid buffer, flush and a stall counter.
// Latency: 1 cycle from accept to *_out when empty, or when one entry is held and drains in the same cycle.
// Backpressure: in_ready depends only on registered state and drops only when both entries are held.
module exe_wb_pipe_reg #(
  parameter int DSIZE         = 16,
  parameter int ASIZE         = 4,
  parameter int ZERO_REG_MASK = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] aluout_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             wen_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] aluout_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             wen_out,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q;
  logic [DSIZE-1:0]   main_dat_q;
  logic [ASIZE-1:0]   main_addr_q;
  logic               main_wen_q;
  logic [DSIZE-1:0]   skid_dat_q;
  logic [ASIZE-1:0]   skid_addr_q;
  logic               skid_wen_q;
  logic [CNT_W-1:0]   stall_q;
  logic [CNT_W-1:0]   stall_d;

  logic accept;
  logic drain;
  logic addr_is_zero;
  logic cap_wen;

  // Handshake decode: both ready and valid come straight from the state register.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // Writes to register 0 are neutralised on capture so WB never sees them.
  assign addr_is_zero = (waddr_in == '0);
  assign cap_wen      = wen_in & ~((ZERO_REG_MASK != 0) & addr_is_zero);

  assign aluout_out = main_dat_q;
  assign waddr_out  = main_addr_q;
  assign wen_out    = main_wen_q & out_valid;
  assign occupancy  = state_q;
  assign stall_cnt  = stall_q;

  // Occupancy FSM with head (main) and second (skid) entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_dat_q  <= '0;
      main_addr_q <= '0;
      main_wen_q  <= 1'b0;
      skid_dat_q  <= '0;
      skid_addr_q <= '0;
      skid_wen_q  <= 1'b0;
    end else if (flush) begin
      // Data registers keep stale contents; out_valid gates them.
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q     <= ONE;
            main_dat_q  <= aluout_in;
            main_addr_q <= waddr_in;
            main_wen_q  <= cap_wen;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_dat_q  <= aluout_in;
            main_addr_q <= waddr_in;
            main_wen_q  <= cap_wen;
          end else if (accept) begin
            state_q     <= FULL;
            skid_dat_q  <= aluout_in;
            skid_addr_q <= waddr_in;
            skid_wen_q  <= cap_wen;
          end else if (drain) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_q     <= ONE;
            main_dat_q  <= skid_dat_q;
            main_addr_q <= skid_addr_q;
            main_wen_q  <= skid_wen_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Saturating stall counter next-state: counts cycles where WB holds off a valid head.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
  end

  // Stall counter register; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_exe_wb_pipe_reg.sv
module tb_exe_wb_pipe_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] aluout_in;
  logic [3:0]  waddr_in;
  logic        wen_in;
  logic        out_ready;

  // Default instance (mask on, 16-bit counter)
  logic        o_in_ready, o_out_valid, o_wen;
  logic [15:0] o_alu;
  logic [3:0]  o_addr;
  logic [1:0]  o_occ;
  logic [15:0] o_stall;
  // Mask-off instance
  logic        nm_in_ready, nm_out_valid, nm_wen;
  logic [15:0] nm_alu;
  logic [3:0]  nm_addr;
  logic [1:0]  nm_occ;
  logic [15:0] nm_stall;
  // 4-bit counter instance
  logic        st_in_ready, st_out_valid, st_wen;
  logic [15:0] st_alu;
  logic [3:0]  st_addr;
  logic [1:0]  st_occ;
  logic [3:0]  st_stall;

  exe_wb_pipe_reg #(.DSIZE(16), .ASIZE(4), .ZERO_REG_MASK(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_in_ready),
    .aluout_in(aluout_in), .waddr_in(waddr_in), .wen_in(wen_in),
    .out_valid(o_out_valid), .out_ready(out_ready), .aluout_out(o_alu),
    .waddr_out(o_addr), .wen_out(o_wen), .occupancy(o_occ), .stall_cnt(o_stall));

  exe_wb_pipe_reg #(.DSIZE(16), .ASIZE(4), .ZERO_REG_MASK(0), .CNT_W(16)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
    .aluout_in(aluout_in), .waddr_in(waddr_in), .wen_in(wen_in),
    .out_valid(nm_out_valid), .out_ready(out_ready), .aluout_out(nm_alu),
    .waddr_out(nm_addr), .wen_out(nm_wen), .occupancy(nm_occ), .stall_cnt(nm_stall));

  exe_wb_pipe_reg #(.DSIZE(16), .ASIZE(4), .ZERO_REG_MASK(1), .CNT_W(4)) dut_st (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(st_in_ready),
    .aluout_in(aluout_in), .waddr_in(waddr_in), .wen_in(wen_in),
    .out_valid(st_out_valid), .out_ready(out_ready), .aluout_out(st_alu),
    .waddr_out(st_addr), .wen_out(st_wen), .occupancy(st_occ), .stall_cnt(st_stall));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered list of held entries plus counters.
  typedef struct {
    logic [15:0] d;
    logic [3:0]  a;
    logic        w;
  } ent_t;

  ent_t m_q[$];
  int   m_c16;
  int   m_c4;
  bit   m_fresh;   // nothing captured since reset, so data outputs are still zero
  int   n_chk;
  int   n_fail;

  function automatic logic exp_wen(input bit mask);
    if (m_q.size() == 0) return 1'b0;
    return m_q[0].w && !(mask && (m_q[0].a == 4'd0));
  endfunction

  function automatic logic [1:0] exp_occ();
    return 2'(m_q.size());
  endfunction

  // Drives one cycle of stimulus and advances the model across the rising edge.
  task automatic step(input logic v, input logic [15:0] d, input logic [3:0] a, input logic w,
                      input logic ordy, input logic fl, input logic r);
    bit   acc, drn, stl;
    ent_t e;
    in_valid  = v;
    aluout_in = d;
    waddr_in  = a;
    wen_in    = w;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    acc = v && (m_q.size() < 2);
    drn = (m_q.size() > 0) && ordy;
    stl = (m_q.size() > 0) && !ordy;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_c16   = 0;
      m_c4    = 0;
      m_fresh = 1'b1;
    end else begin
      if (stl) begin
        if (m_c16 < 65535) m_c16++;
        if (m_c4 < 15) m_c4++;
      end
      if (fl) begin
        m_q.delete();
      end else begin
        if (drn) void'(m_q.pop_front());
        if (acc) begin
          e.d = d; e.a = a; e.w = w;
          m_q.push_back(e);
          m_fresh = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 16'h0, 4'h0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (o_occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", o_occ); end
    n_chk++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", o_in_ready); end
    n_chk++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", o_out_valid); end
    n_chk++; if (o_alu !== 16'h0 || o_addr !== 4'h0 || o_wen !== 1'b0) begin
      n_fail++; $display("FAIL reset_outs: got %h/%h/%b want 0/0/0", o_alu, o_addr, o_wen); end
    n_chk++; if (o_stall !== 16'd0 || st_stall !== 4'd0) begin
      n_fail++; $display("FAIL reset_stall: got %0d/%0d want 0/0", o_stall, st_stall); end
  endtask

  task automatic test_streaming();
    step(1'b1, 16'h1234, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    n_chk++; if (o_out_valid !== 1'b1 || o_alu !== 16'h1234 || o_addr !== 4'd3 || o_wen !== 1'b1) begin
      n_fail++; $display("FAIL stream_first: got v%b %h/%h/%b want v1 1234/3/1", o_out_valid, o_alu, o_addr, o_wen); end
    n_chk++; if (o_occ !== 2'd1 || o_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stream_occ1: got occ %0d rdy %b want 1/1", o_occ, o_in_ready); end
    step(1'b1, 16'hBEEF, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    n_chk++; if (o_out_valid !== 1'b1 || o_alu !== 16'hBEEF || o_addr !== 4'd5 || o_wen !== 1'b1) begin
      n_fail++; $display("FAIL stream_second: got v%b %h/%h/%b want v1 beef/5/1", o_out_valid, o_alu, o_addr, o_wen); end
    n_chk++; if (o_occ !== 2'd1 || o_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stream_occ2: got occ %0d rdy %b want 1/1", o_occ, o_in_ready); end
    idle(1'b1);
    n_chk++; if (o_occ !== 2'd0 || o_stall !== 16'd0) begin
      n_fail++; $display("FAIL stream_end: got occ %0d stall %0d want 0/0", o_occ, o_stall); end
  endtask

  task automatic test_backpressure();
    step(1'b1, 16'h0001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++; if (o_occ !== 2'd2 || o_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full: got occ %0d rdy %b want 2/0", o_occ, o_in_ready); end
    for (int i = 0; i < 2; i++) step(1'b1, 16'h0003, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++; if (o_occ !== 2'd2 || o_alu !== 16'h0001) begin
      n_fail++; $display("FAIL bp_hold: got occ %0d head %h want 2/0001", o_occ, o_alu); end
    step(1'b1, 16'h0003, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    n_chk++; if (o_alu !== 16'h0002 || o_addr !== 4'd2 || o_occ !== 2'd1) begin
      n_fail++; $display("FAIL bp_B: got %h/%h occ %0d want 0002/2 occ 1", o_alu, o_addr, o_occ); end
    step(1'b1, 16'h0003, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    n_chk++; if (o_alu !== 16'h0003 || o_addr !== 4'd6 || o_occ !== 2'd1) begin
      n_fail++; $display("FAIL bp_C: got %h/%h occ %0d want 0003/6 occ 1", o_alu, o_addr, o_occ); end
    idle(1'b1);
    n_chk++; if (o_occ !== 2'd0) begin n_fail++; $display("FAIL bp_drained: got occ %0d want 0", o_occ); end
    n_chk++; if (o_stall !== 16'd3 || o_stall !== 16'(m_c16)) begin
      n_fail++; $display("FAIL bp_stall: got %0d want 3", o_stall); end
  endtask

  task automatic test_zero_mask();
    step(1'b1, 16'hFFFF, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_chk++; if (o_out_valid !== 1'b1 || o_wen !== 1'b0 || o_alu !== 16'hFFFF || o_addr !== 4'd0) begin
      n_fail++; $display("FAIL mask_on: got v%b wen %b %h/%h want v1 wen 0 ffff/0", o_out_valid, o_wen, o_alu, o_addr); end
    n_chk++; if (nm_out_valid !== 1'b1 || nm_wen !== 1'b1 || nm_alu !== 16'hFFFF) begin
      n_fail++; $display("FAIL mask_off: got v%b wen %b %h want v1 wen 1 ffff", nm_out_valid, nm_wen, nm_alu); end
    idle(1'b1);
  endtask

  task automatic test_flush();
    int pre;
    step(1'b1, 16'hAAAA, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hBBBB, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    pre = m_c16;
    step(1'b1, 16'hCCCC, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    n_chk++; if (o_occ !== 2'd0 || o_out_valid !== 1'b0 || o_wen !== 1'b0) begin
      n_fail++; $display("FAIL flush_empty: got occ %0d v%b wen %b want 0/0/0", o_occ, o_out_valid, o_wen); end
    n_chk++; if (o_stall !== 16'(pre + 1) || o_stall === 16'd0) begin
      n_fail++; $display("FAIL flush_stall: got %0d want %0d", o_stall, pre + 1); end
    idle(1'b1);
    n_chk++; if (o_out_valid !== 1'b0 || o_occ !== 2'd0) begin
      n_fail++; $display("FAIL flush_gone: got v%b occ %0d want 0/0", o_out_valid, o_occ); end
  endtask

  task automatic test_saturation();
    step(1'b1, 16'h5555, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    n_chk++; if (st_stall !== 4'd15) begin n_fail++; $display("FAIL sat_4bit: got %0d want 15", st_stall); end
    n_chk++; if (o_stall !== 16'(m_c16)) begin n_fail++; $display("FAIL sat_16bit: got %0d want %0d", o_stall, m_c16); end
    step(1'b1, 16'h6666, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++; if (st_stall !== 4'd15 || st_occ !== 2'd2) begin
      n_fail++; $display("FAIL sat_hold: got stall %0d occ %0d want 15/2", st_stall, st_occ); end
    step(1'b1, 16'h7777, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    n_chk++; if (o_occ !== 2'd0 || o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstpri_ctl: got occ %0d rdy %b v%b want 0/1/0", o_occ, o_in_ready, o_out_valid); end
    n_chk++; if (o_alu !== 16'h0 || o_addr !== 4'h0 || o_wen !== 1'b0) begin
      n_fail++; $display("FAIL rstpri_dat: got %h/%h/%b want 0/0/0", o_alu, o_addr, o_wen); end
    n_chk++; if (o_stall !== 16'd0 || st_stall !== 4'd0) begin
      n_fail++; $display("FAIL rstpri_stall: got %0d/%0d want 0/0", o_stall, st_stall); end
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic v, w, ordy, fl, r;
    logic [15:0] d;
    logic [3:0]  a;
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      d    = 16'($urandom);
      a    = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      w    = ($urandom_range(0, 4) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      r    = ($urandom_range(0, 60) == 0);
      step(v, d, a, w, ordy, fl, r);
      n_chk++; if (o_occ !== exp_occ() || nm_occ !== exp_occ() || st_occ !== exp_occ()) begin
        n_fail++; $display("FAIL rnd_occ[%0d]: got %0d/%0d/%0d want %0d", i, o_occ, nm_occ, st_occ, exp_occ()); end
      n_chk++; if (o_in_ready !== (m_q.size() < 2) || o_out_valid !== (m_q.size() > 0)) begin
        n_fail++; $display("FAIL rnd_hs[%0d]: got rdy %b v%b want %b/%b", i, o_in_ready, o_out_valid,
                           m_q.size() < 2, m_q.size() > 0); end
      n_chk++; if (o_wen !== exp_wen(1'b1) || nm_wen !== exp_wen(1'b0) || st_wen !== exp_wen(1'b1)) begin
        n_fail++; $display("FAIL rnd_wen[%0d]: got %b/%b/%b want %b/%b/%b", i, o_wen, nm_wen, st_wen,
                           exp_wen(1'b1), exp_wen(1'b0), exp_wen(1'b1)); end
      if (m_q.size() > 0) begin
        n_chk++; if (o_alu !== m_q[0].d || o_addr !== m_q[0].a || nm_alu !== m_q[0].d) begin
          n_fail++; $display("FAIL rnd_head[%0d]: got %h/%h want %h/%h", i, o_alu, o_addr, m_q[0].d, m_q[0].a); end
      end else if (m_fresh) begin
        n_chk++; if (o_alu !== 16'h0 || o_addr !== 4'h0) begin
          n_fail++; $display("FAIL rnd_rstdat[%0d]: got %h/%h want 0/0", i, o_alu, o_addr); end
      end
      n_chk++; if (o_stall !== 16'(m_c16) || nm_stall !== 16'(m_c16) || st_stall !== 4'(m_c4)) begin
        n_fail++; $display("FAIL rnd_stall[%0d]: got %0d/%0d/%0d want %0d/%0d", i, o_stall, nm_stall, st_stall,
                           m_c16, m_c4); end
    end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    m_c16     = 0;
    m_c4      = 0;
    m_fresh   = 1'b1;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    aluout_in = 16'h0;
    waddr_in  = 4'h0;
    wen_in    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_zero_mask();
    test_flush();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
